// File: rtl/legv8_pkg.sv
// Shared LEGv8 register-file constants and types.
package legv8_pkg;

  localparam int unsigned DATA_W_DEFAULT   = 64;
  localparam int unsigned NUM_REGS_DEFAULT = 32;
  localparam int unsigned XZR              = 31;

  typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer scoreboard: issue sets, writeback clears, issue wins a tie.
module regfile_scoreboard
  import legv8_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = XZR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (i == ZERO_REG) begin
        w_busy_d[i] = 1'b0;
      end else if (issue_en && issue_addr == ADDR_W'(i)) begin
        w_busy_d[i] = 1'b1;
      end else if (clr_en && clr_addr == ADDR_W'(i)) begin
        w_busy_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// LEGv8 register file with busy scoreboard; XZR reads as zero and is never written or marked busy.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = XZR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [NUM_REGS-1:0] w_busy_vec;
  logic [DATA_W-1:0]   w_rd_data1, w_rd_data2;
  logic                w_rd_busy1, w_rd_busy2;

  // One-hot write select; empty for XZR and out-of-range addresses.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i)) && (i != ZERO_REG);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr_en     (wr_en),
    .clr_addr   (wr_addr),
    .busy_vec   (w_busy_vec)
  );

  always_comb begin
    w_rd_data1 = '0;
    w_rd_data2 = '0;
    w_rd_busy1 = 1'b0;
    w_rd_busy2 = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (i != ZERO_REG && rd_addr1 == ADDR_W'(i)) begin
        w_rd_data1 = r_regs[i];
        w_rd_busy1 = w_busy_vec[i];
      end
      if (i != ZERO_REG && rd_addr2 == ADDR_W'(i)) begin
        w_rd_data2 = r_regs[i];
        w_rd_busy2 = w_busy_vec[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // |w_wr_sel already excludes XZR and out-of-range write addresses.
    if (|w_wr_sel && wr_addr == rd_addr1) begin
      w_rd_data1 = wr_data;
      w_rd_busy1 = issue_en && (issue_addr == rd_addr1);
    end
    if (|w_wr_sel && wr_addr == rd_addr2) begin
      w_rd_data2 = wr_data;
      w_rd_busy2 = issue_en && (issue_addr == rd_addr2);
    end
`endif
  end

  assign rd_data1 = w_rd_data1;
  assign rd_data2 = w_rd_data2;
  assign rd_busy1 = w_rd_busy1;
  assign rd_busy2 = w_rd_busy2;
  assign busy_vec = w_busy_vec;

endmodule
